// File: rtl/uart_tx_rr_arbiter.sv
// uart_tx_rr_arbiter: shares one UART TX byte interface between three
// clients with round-robin arbitration. A client requests when any bit of
// its 3-bit request vector is set. Each transfer is granted, held until the
// transmitter accepts it (or a stall timeout drops it), then acknowledged.
module uart_tx_rr_arbiter #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        a1,
    input  logic [2:0]        a2,
    input  logic [2:0]        a3,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    output logic              y1,
    output logic              y2,
    output logic              y3,
    output logic [2:0]        grant,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Registered state and outputs
    state_t             r_state;
    logic [2:0]         r_grant;
    logic               r_tx_valid;
    logic [DATA_W-1:0]  r_tx_data;
    logic               r_busy;
    logic [2:0]         r_ack;
    logic               r_timeout_err;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_last;      // one-hot owner of the previous transfer

    // Next-state values
    state_t             w_state_nxt;
    logic [2:0]         w_grant_nxt;
    logic               w_tx_valid_nxt;
    logic [DATA_W-1:0]  w_tx_data_nxt;
    logic               w_busy_nxt;
    logic [2:0]         w_ack_nxt;
    logic               w_timeout_err_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [2:0]         w_last_nxt;

    logic [2:0]         w_req;
    logic [2:0]         w_pick;
    logic [DATA_W-1:0]  w_pick_data;
    logic               w_expire;

    // First requesting client in rotation order after the previous owner
    // (1 -> 2 -> 3 -> 1). Returns a one-hot vector, or zero with no request.
    function automatic logic [2:0] rr_pick(input logic [2:0] req,
                                           input logic [2:0] last);
        logic [2:0] pick;
        pick = 3'b000;
        case (last)
            3'b001: begin
                if (req[1])      pick = 3'b010;
                else if (req[2]) pick = 3'b100;
                else if (req[0]) pick = 3'b001;
                else             pick = 3'b000;
            end
            3'b010: begin
                if (req[2])      pick = 3'b100;
                else if (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
                else             pick = 3'b000;
            end
            default: begin
                if (req[0])      pick = 3'b001;
                else if (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
                else             pick = 3'b000;
            end
        endcase
        return pick;
    endfunction

    // Request decode is a plain OR-reduce of each client's vector
    assign w_req = {|a3, |a2, |a1};
    assign w_pick = rr_pick(w_req, r_last);
    assign w_expire = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    // Byte of the client being granted this cycle
    always_comb begin
        w_pick_data = {DATA_W{1'b0}};
        case (w_pick)
            3'b001:  w_pick_data = d1;
            3'b010:  w_pick_data = d2;
            3'b100:  w_pick_data = d3;
            default: w_pick_data = {DATA_W{1'b0}};
        endcase
    end

    // Next-state and next-output logic for the grant/send sequence
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_tx_valid_nxt    = r_tx_valid;
        w_tx_data_nxt     = r_tx_data;
        w_busy_nxt        = r_busy;
        w_ack_nxt         = 3'b000;
        w_timeout_err_nxt = 1'b0;
        w_cnt_nxt         = r_cnt;
        w_last_nxt        = r_last;
        case (r_state)
            IDLE: begin
                // tx_ready is ignored here; only a request starts a transfer
                if (|w_req) begin
                    w_state_nxt    = SEND;
                    w_grant_nxt    = w_pick;
                    w_tx_valid_nxt = 1'b1;
                    w_tx_data_nxt  = w_pick_data;
                    w_busy_nxt     = 1'b1;
                    w_cnt_nxt      = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt    = IDLE;
                    w_grant_nxt    = 3'b000;
                    w_tx_valid_nxt = 1'b0;
                    w_busy_nxt     = 1'b0;
                end
            end
            SEND: begin
                // Accept takes precedence over an expiry in the same cycle
                if (tx_ready) begin
                    w_state_nxt    = IDLE;
                    w_ack_nxt      = r_grant;
                    w_last_nxt     = r_grant;
                    w_grant_nxt    = 3'b000;
                    w_tx_valid_nxt = 1'b0;
                    w_busy_nxt     = 1'b0;
                end else if (w_expire) begin
                    // Stalled owner is dropped and loses priority
                    w_state_nxt       = IDLE;
                    w_timeout_err_nxt = 1'b1;
                    w_last_nxt        = r_grant;
                    w_grant_nxt       = 3'b000;
                    w_tx_valid_nxt    = 1'b0;
                    w_busy_nxt        = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_grant_nxt    = 3'b000;
                w_tx_valid_nxt = 1'b0;
                w_busy_nxt     = 1'b0;
                w_cnt_nxt      = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and output registers; reset abandons any transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_grant       <= 3'b000;
            r_tx_valid    <= 1'b0;
            r_tx_data     <= {DATA_W{1'b0}};
            r_busy        <= 1'b0;
            r_ack         <= 3'b000;
            r_timeout_err <= 1'b0;
            r_cnt         <= {CNT_W{1'b0}};
            r_last        <= 3'b100;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_tx_valid    <= w_tx_valid_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_busy        <= w_busy_nxt;
            r_ack         <= w_ack_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_cnt         <= w_cnt_nxt;
            r_last        <= w_last_nxt;
        end
    end

    assign grant       = r_grant;
    assign tx_valid    = r_tx_valid;
    assign tx_data     = r_tx_data;
    assign busy        = r_busy;
    assign y1          = r_ack[0];
    assign y2          = r_ack[1];
    assign y3          = r_ack[2];
    assign timeout_err = r_timeout_err;

endmodule
